// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        HOLD      = 3'd3,
        RUN       = 3'd4
    } state_e;

    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MIN_COUNT       = 1;

    // Counter only needs to reach (largest count - 1); never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop single-bit synchroniser with synchronous reset to 0.
module bit_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives PLL RESET from the reference clock, qualifies LOCK and gates the downstream reset.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned PLL_RST_CYCLES = 32,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lock_i,
    output logic             pll_reset,
    output logic             rst_out,
    output logic             ready,
    output logic [CNT_W-1:0] loss_count,
    output logic             timeout_err
);

    localparam int unsigned CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES,
                                           HOLD_CYCLES);
    localparam logic [CW-1:0]    RST_LAST     = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0]    TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]    STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]    HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_MAX     = '1;

    if (SYNC_STAGES < MIN_SYNC_STAGES || PLL_RST_CYCLES < MIN_COUNT ||
        LOCK_TIMEOUT < MIN_COUNT || STABLE_CYCLES < MIN_COUNT ||
        HOLD_CYCLES < MIN_COUNT || CNT_W < MIN_COUNT) begin : g_param_check
        $error("pll_lock_supervisor: illegal parameter value");
    end

    logic lock_s;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (lock_i),
        .q     (lock_s)
    );

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             timeout_q, timeout_d;
    logic             pll_reset_q, rst_out_q, ready_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        loss_d    = loss_q;
        timeout_d = timeout_q;

        case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // A lock arriving on the timeout cycle takes priority over the retry.
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = PLL_RST;
                    timeout_d = 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q;
                if (!lock_s) begin
                    state_d = PLL_RST;
                    if (loss_q != LOSS_MAX) loss_d = loss_q + 1'b1;
                end
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            loss_q      <= '0;
            timeout_q   <= 1'b0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            timeout_q   <= timeout_d;
            // Outputs are registered from the next state so they change with it.
            pll_reset_q <= (state_d == PLL_RST);
            rst_out_q   <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign pll_reset   = pll_reset_q;
    assign rst_out     = rst_out_q;
    assign ready       = ready_q;
    assign loss_count  = loss_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed and randomized bench for pll_lock_supervisor against a behavioural lock model.
module tb_pll_lock_supervisor;

    localparam int unsigned SYNC_STAGES    = 2;
    localparam int unsigned PLL_RST_CYCLES = 4;
    localparam int unsigned LOCK_TIMEOUT   = 64;
    localparam int unsigned STABLE_CYCLES  = 8;
    localparam int unsigned HOLD_CYCLES    = 4;
    localparam int unsigned CNT_W          = 2;
    // Consecutive synchronised-high samples needed from WAIT_LOCK to RUN.
    localparam int QUALIFY  = 1 + STABLE_CYCLES + HOLD_CYCLES;
    localparam int LOSS_SAT = 2 ** CNT_W - 1;

    localparam int PH_RESET = 0;
    localparam int PH_ACQ   = 1;
    localparam int PH_RUN   = 2;

    localparam int SEL_RST = 0;
    localparam int SEL_PLL = 1;
    localparam int SEL_TMO = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             lock_i = 1'b0;
    logic             pll_reset, rst_out, ready, timeout_err;
    logic [CNT_W-1:0] loss_count;

    int checks = 0;
    int failures = 0;

    // Reference model state.
    bit syncq[$];
    int m_phase, m_age, m_lows, m_good, m_loss;
    bit m_tmo;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .SYNC_STAGES    (SYNC_STAGES),
        .PLL_RST_CYCLES (PLL_RST_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .lock_i      (lock_i),
        .pll_reset   (pll_reset),
        .rst_out     (rst_out),
        .ready       (ready),
        .loss_count  (loss_count),
        .timeout_err (timeout_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lock qualifies after QUALIFY high samples in a row, times out after LOCK_TIMEOUT
    // low samples in a row, and a drop after some highs restarts the timeout window.
    task automatic model_step(input bit r, input bit l);
        bit ls;
        if (r) begin
            syncq = {};
            repeat (SYNC_STAGES) syncq.push_back(1'b0);
            m_phase = PH_RESET;
            m_age   = 0;
            m_loss  = 0;
            m_tmo   = 1'b0;
            return;
        end
        ls = syncq.pop_front();
        syncq.push_back(l);
        case (m_phase)
            PH_RESET: begin
                m_age++;
                if (m_age == PLL_RST_CYCLES) begin
                    m_phase = PH_ACQ;
                    m_lows  = 0;
                    m_good  = 0;
                end
            end
            PH_ACQ: begin
                if (ls) begin
                    m_good++;
                    if (m_good == QUALIFY) m_phase = PH_RUN;
                end else if (m_good > 0) begin
                    m_good = 0;
                    m_lows = 0;
                end else begin
                    m_lows++;
                    if (m_lows == LOCK_TIMEOUT) begin
                        m_tmo   = 1'b1;
                        m_phase = PH_RESET;
                        m_age   = 0;
                    end
                end
            end
            default: begin
                if (!ls) begin
                    if (m_loss < LOSS_SAT) m_loss++;
                    m_phase = PH_RESET;
                    m_age   = 0;
                end
            end
        endcase
    endtask

    task automatic tick();
        bit r, l;
        logic [5:0] exp_v;
        r = reset;
        l = lock_i;
        @(posedge clk);
        #1;
        model_step(r, l);
        exp_v = {m_phase == PH_RESET, m_phase != PH_RUN, m_phase == PH_RUN, m_tmo,
                 CNT_W'(m_loss)};
        check_val("model_outputs", {pll_reset, rst_out, ready, timeout_err, loss_count}, exp_v);
    endtask

    function automatic logic get_sig(input int sel);
        case (sel)
            SEL_RST: return rst_out;
            SEL_PLL: return pll_reset;
            default: return timeout_err;
        endcase
    endfunction

    // Ticks until the selected output equals lvl; n = -1 if the budget runs out.
    task automatic wait_for(input int sel, input logic lvl, input int limit, output int n);
        n = 0;
        while (get_sig(sel) !== lvl && n < limit) begin
            tick();
            n++;
        end
        if (get_sig(sel) !== lvl) n = -1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int n, n1, n2, len;

        // Reset state
        reset  = 1'b1;
        lock_i = 1'b1;
        tick();
        tick();
        check_val("reset_state", {pll_reset, rst_out, ready, timeout_err, loss_count}, 6'b110000);

        // Cold start with lock tied high
        reset = 1'b0;
        wait_for(SEL_PLL, 1'b0, 50, n);
        check_val("cold_pll_reset_len", n, PLL_RST_CYCLES);
        wait_for(SEL_RST, 1'b0, 100, n);
        check_val("cold_rst_fall", n, QUALIFY);
        check_val("cold_ready", ready, 1'b1);

        // Repeated loss in RUN, loss_count saturates
        for (int i = 0; i < 4; i++) begin
            lock_i = 1'b0;
            wait_for(SEL_RST, 1'b1, 20, n);
            check_val("loss_rst_latency", n, SYNC_STAGES + 1);
            check_val("loss_count", loss_count, (i + 1 < LOSS_SAT) ? i + 1 : LOSS_SAT);
            check_val("loss_pll_reset", pll_reset, 1'b1);
            lock_i = 1'b1;
            wait_for(SEL_RST, 1'b0, 200, n);
            check_val("loss_relock", n, PLL_RST_CYCLES + QUALIFY);
        end

        // Reset while in RUN
        pulse_reset();
        check_val("reset_in_run", {pll_reset, rst_out, ready, timeout_err, loss_count}, 6'b110000);
        wait_for(SEL_PLL, 1'b0, 50, n);
        check_val("rerun_pll_reset_len", n, PLL_RST_CYCLES);
        wait_for(SEL_RST, 1'b0, 100, n);
        check_val("rerun_rst_fall", n, QUALIFY);

        // Three-cycle lock dropout in the middle of STABLE
        pulse_reset();
        repeat (8) tick();
        lock_i = 1'b0;
        repeat (3) tick();
        lock_i = 1'b1;
        wait_for(SEL_RST, 1'b0, 100, n);
        check_val("stable_drop_requal", n, SYNC_STAGES + 1 + STABLE_CYCLES + HOLD_CYCLES);
        check_val("stable_drop_loss", loss_count, 0);

        // Lock never arrives: periodic retries and sticky timeout
        lock_i = 1'b0;
        pulse_reset();
        wait_for(SEL_TMO, 1'b1, 200, n);
        check_val("first_timeout", n, PLL_RST_CYCLES + LOCK_TIMEOUT);
        check_val("timeout_pll_reset", pll_reset, 1'b1);
        for (int i = 0; i < 2; i++) begin
            wait_for(SEL_PLL, 1'b0, 50, n1);
            wait_for(SEL_PLL, 1'b1, 200, n2);
            check_val("retry_period", n1 + n2, PLL_RST_CYCLES + LOCK_TIMEOUT);
            check_val("retry_pulse_len", n1, PLL_RST_CYCLES);
        end
        check_val("timeout_rst_out", rst_out, 1'b1);

        // Lock reaches lock_s exactly on the timeout cycle: lock wins
        pulse_reset();
        repeat (PLL_RST_CYCLES + LOCK_TIMEOUT - SYNC_STAGES - 1) tick();
        lock_i = 1'b1;
        repeat (SYNC_STAGES + 1) tick();
        check_val("edge_lock_wins_tmo", timeout_err, 1'b0);
        check_val("edge_lock_wins_pll", pll_reset, 1'b0);
        wait_for(SEL_RST, 1'b0, 100, n);
        check_val("edge_lock_wins_run", n, QUALIFY - 1);

        // One cycle later the timeout fires first
        lock_i = 1'b0;
        pulse_reset();
        repeat (PLL_RST_CYCLES + LOCK_TIMEOUT - SYNC_STAGES) tick();
        lock_i = 1'b1;
        repeat (SYNC_STAGES) tick();
        check_val("edge_late_tmo", timeout_err, 1'b1);
        check_val("edge_late_pll", pll_reset, 1'b1);

        // Randomized lock activity with occasional resets
        pulse_reset();
        for (int s = 0; s < 120; s++) begin
            lock_i = 1'($urandom_range(0, 1));
            len = lock_i ? $urandom_range(1, 40) : $urandom_range(1, 90);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 499) == 0) reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
